// File: rtl/spi_tx_serializer_if.sv
// Word handshake between the TX control FSM (master) and the SPI serializer (slave).
// Carries the data word, valid/ready pair, end-of-transfer pulse and busy flag.
`timescale 1ns/1ps
interface spi_tx_serializer_if #(
   parameter int DWIDTH = 32
);
   logic [DWIDTH-1:0] tx_data_i;
   logic              tx_vld_i;
   logic              tx_rdy_o;
   logic              tx_eot_o;
   logic              busy_o;

   modport master (
      output tx_data_i, tx_vld_i,
      input  tx_rdy_o, tx_eot_o, busy_o
   );

   modport slave (
      input  tx_data_i, tx_vld_i,
      output tx_rdy_o, tx_eot_o, busy_o
   );
endinterface

// File: rtl/spi_tx_serializer.sv
// SPI TX PHY: serialises one word MSB-first with programmable CPOL/CPHA, SCLK divider and length.
// eot at T+1+(2*len+2)*(div+1) after handshake T; tx_rdy_o low from handshake until the cycle after eot.
`timescale 1ns/1ps
module spi_tx_serializer #(
   parameter int DWIDTH = 32,
   parameter int DIV_W  = 8,
   parameter int LEN_W  = 6
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               cpol_i,
   input  logic               cpha_i,
   input  logic [DIV_W-1:0]   clk_div_i,
   input  logic [LEN_W-1:0]   len_i,
   spi_tx_serializer_if.slave tx,
   output logic               sdo_o,
   output logic               sclk_o,
   output logic               cs_n_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LEAD  = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] TRAIL = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [LEN_W-1:0] DW_LEN = LEN_W'(DWIDTH);

   logic [2:0]        state;
   logic [DWIDTH-1:0] shreg;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_cnt;
   logic [LEN_W:0]    edge_cnt;
   logic [LEN_W:0]    edge_last;
   logic              cpol_q;
   logic              cpha_q;

   logic [LEN_W-1:0]  len_eff;
   logic [LEN_W-1:0]  sh_amt;
   logic [DWIDTH-1:0] aligned;
   logic              tick;
   logic              hs;
   logic              shift_now;

   always_comb begin
      len_eff = len_i;
      if (len_i == '0 || len_i > DW_LEN) begin
         len_eff = DW_LEN;
      end
   end

   // Left-justify the word so bit len-1 sits at the MSB; higher bits fall off.
   assign sh_amt  = DW_LEN - len_eff;
   assign aligned = tx.tx_data_i << sh_amt;

   assign tick = (div_cnt == div_q);
   assign hs   = tx.tx_vld_i && tx.tx_rdy_o;

   // edge_cnt holds the index of the edge about to be produced; even indices are leading edges.
   // CPHA=0 changes data on trailing edges except the last, CPHA=1 on every leading edge.
   always_comb begin
      shift_now = 1'b0;
      if (cpha_q) begin
         shift_now = ~edge_cnt[0];
      end else begin
         shift_now = edge_cnt[0] && (edge_cnt != edge_last - 1'b1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= IDLE;
         tx.tx_rdy_o <= 1'b0;
         tx.tx_eot_o <= 1'b0;
         tx.busy_o   <= 1'b0;
         sdo_o       <= 1'b0;
         sclk_o      <= 1'b0;
         cs_n_o      <= 1'b1;
         shreg       <= '0;
         div_q       <= '0;
         div_cnt     <= '0;
         edge_cnt    <= '0;
         edge_last   <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
      end else begin
         tx.tx_eot_o <= 1'b0;
         case (state)
            IDLE: begin
               tx.tx_rdy_o <= 1'b1;
               sclk_o      <= cpol_i;
               div_cnt     <= '0;
               if (hs) begin
                  state       <= LEAD;
                  tx.tx_rdy_o <= 1'b0;
                  tx.busy_o   <= 1'b1;
                  cs_n_o      <= 1'b0;
                  cpol_q      <= cpol_i;
                  cpha_q      <= cpha_i;
                  div_q       <= clk_div_i;
                  edge_last   <= {len_eff, 1'b0};
                  edge_cnt    <= '0;
                  // CPHA=0 presents the first bit now, so the register starts one bit ahead.
                  if (cpha_i) begin
                     shreg <= aligned;
                     sdo_o <= 1'b0;
                  end else begin
                     shreg <= aligned << 1;
                     sdo_o <= aligned[DWIDTH-1];
                  end
               end
            end

            LEAD: begin
               if (tick) begin
                  state    <= SHIFT;
                  div_cnt  <= '0;
                  sclk_o   <= ~sclk_o;
                  edge_cnt <= {{LEN_W{1'b0}}, 1'b1};
                  if (cpha_q) begin
                     sdo_o <= shreg[DWIDTH-1];
                     shreg <= shreg << 1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            SHIFT: begin
               if (tick) begin
                  div_cnt <= '0;
                  if (edge_cnt == edge_last) begin
                     state  <= TRAIL;
                     sclk_o <= cpol_q;
                  end else begin
                     sclk_o   <= ~sclk_o;
                     edge_cnt <= edge_cnt + 1'b1;
                     if (shift_now) begin
                        sdo_o <= shreg[DWIDTH-1];
                        shreg <= shreg << 1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            TRAIL: begin
               if (tick) begin
                  state       <= DONE;
                  div_cnt     <= '0;
                  cs_n_o      <= 1'b1;
                  tx.tx_eot_o <= 1'b1;
                  tx.busy_o   <= 1'b0;
                  sdo_o       <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            DONE: begin
               // sclk_o keeps the latched CPOL here; the live cpol_i shows up one IDLE cycle later.
               state       <= IDLE;
               tx.tx_rdy_o <= 1'b1;
               div_cnt     <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Bench for spi_tx_serializer: waveform model per cycle, bit decoder, directed cases and random traffic.
`timescale 1ns/1ps
module tb_spi_tx_serializer;
   localparam int DWIDTH = 32;
   localparam int DIV_W  = 8;
   localparam int LEN_W  = 6;

   logic             clk_i = 1'b0;
   logic             rstn_i = 1'b0;
   logic             cpol_i = 1'b0;
   logic             cpha_i = 1'b0;
   logic [DIV_W-1:0] clk_div_i = '0;
   logic [LEN_W-1:0] len_i = '0;
   logic             sdo_o;
   logic             sclk_o;
   logic             cs_n_o;

   spi_tx_serializer_if #(.DWIDTH(DWIDTH)) tx_if ();

   spi_tx_serializer #(.DWIDTH(DWIDTH), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .cpol_i    (cpol_i),
      .cpha_i    (cpha_i),
      .clk_div_i (clk_div_i),
      .len_i     (len_i),
      .tx        (tx_if.slave),
      .sdo_o     (sdo_o),
      .sclk_o    (sclk_o),
      .cs_n_o    (cs_n_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_cyc   = 0;
   int eot_cyc  = 0;

   // expected outputs for the current cycle
   logic e_rdy, e_eot, e_busy, e_sdo, e_sclk, e_cs_n;
   bit          m_act = 0;
   int          m_c, m_n, m_len, m_hp;
   bit          m_cpol, m_cpha;
   logic [31:0] m_data;

   // bit decoder state
   logic [31:0] dec_word = '0;
   int          dec_bits = 0;
   int          dec_edges = 0;
   bit          dec_cpol = 0;
   bit          dec_cpha = 0;
   int          cs_run = 0;
   int          last_gap = 0;
   logic        p_cs = 1'b1;
   logic        p_sclk = 1'b0;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, want %b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_reset_vals();
      e_rdy = 0; e_eot = 0; e_busy = 0; e_sdo = 0; e_sclk = 0; e_cs_n = 1;
   endtask

   task automatic set_idle(input logic pol);
      e_rdy = 1; e_eot = 0; e_busy = 0; e_sdo = 0; e_sclk = pol; e_cs_n = 1;
   endtask

   // Outputs at cycle offset c (1 = first LEAD cycle) of a transfer, from the half-period timeline.
   task automatic wave(input int c);
      int h, s, b;
      e_rdy = 0;
      if (c == m_n) begin
         e_cs_n = 1; e_eot = 1; e_busy = 0; e_sdo = 0; e_sclk = m_cpol;
      end else begin
         h = (c - 1) / m_hp;
         e_cs_n = 0; e_eot = 0; e_busy = 1;
         if (h == 0) begin
            e_sclk = m_cpol;
            e_sdo  = m_cpha ? 1'b0 : m_data[m_len-1];
         end else if (h <= 2 * m_len) begin
            s = h - 1;
            e_sclk = m_cpol ^ ((s % 2) == 0);
            b = m_cpha ? s / 2 : (s + 1) / 2;
            if (b > m_len - 1) b = m_len - 1;
            e_sdo = m_data[m_len-1-b];
         end else begin
            e_sclk = m_cpol;
            e_sdo  = m_data[0];
         end
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Compare process: checks every cycle, then advances the model using the inputs the next edge sees.
   initial begin
      set_reset_vals();
      forever begin
         @(negedge clk_i);
         if (!rstn_i) begin
            set_reset_vals();
            m_act = 0;
         end
         chk("tx_rdy_o", tx_if.tx_rdy_o, e_rdy);
         chk("tx_eot_o", tx_if.tx_eot_o, e_eot);
         chk("busy_o",   tx_if.busy_o,   e_busy);
         chk("sdo_o",    sdo_o,          e_sdo);
         chk("sclk_o",   sclk_o,         e_sclk);
         chk("cs_n_o",   cs_n_o,         e_cs_n);
         if (tx_if.tx_eot_o === 1'b1) eot_cyc = cyc;
         if (rstn_i) begin
            if (m_act) begin
               m_c++;
               if (m_c > m_n) begin
                  m_act = 0;
                  set_idle(m_cpol);
               end else begin
                  wave(m_c);
               end
            end else if (e_rdy && tx_if.tx_vld_i) begin
               hs_cyc = cyc;
               m_len  = int'(len_i);
               if (m_len == 0 || m_len > DWIDTH) m_len = DWIDTH;
               m_data = tx_if.tx_data_i;
               m_cpol = cpol_i;
               m_cpha = cpha_i;
               m_hp   = int'(clk_div_i) + 1;
               m_n    = (2 * m_len + 2) * m_hp + 1;
               m_act  = 1;
               m_c    = 1;
               wave(1);
            end else begin
               set_idle(cpol_i);
            end
         end
      end
   end

   // Decoder: shifts in sdo_o on each sampling edge while cs_n_o is low, and measures cs_n_o gaps.
   initial forever begin
      @(negedge clk_i);
      if (!cs_n_o && !p_cs && sclk_o !== p_sclk) begin
         dec_edges++;
         if ((p_sclk == dec_cpol) ^ dec_cpha) begin
            dec_word = {dec_word[30:0], sdo_o};
            dec_bits++;
         end
      end
      if (cs_n_o) begin
         cs_run++;
      end else begin
         if (p_cs && cs_run > 0) last_gap = cs_run;
         cs_run = 0;
      end
      p_cs   = cs_n_o;
      p_sclk = sclk_o;
   end

   task automatic dec_clear(input bit pol, input bit pha);
      dec_word = '0; dec_bits = 0; dec_edges = 0; dec_cpol = pol; dec_cpha = pha;
   endtask

   task automatic send(input logic [31:0] d, input logic [LEN_W-1:0] l, input logic [DIV_W-1:0] dv,
                       input logic pol, input logic pha, input bit hold);
      int t = 0;
      tx_if.tx_data_i = d; len_i = l; clk_div_i = dv; cpol_i = pol; cpha_i = pha;
      tx_if.tx_vld_i = 1'b1;
      @(negedge clk_i);
      while (tx_if.tx_rdy_o !== 1'b1 && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 3000) begin
         n_checks++; n_fail++;
         $display("FAIL handshake timeout for word 0x%0h", d);
      end
      @(posedge clk_i); #1;
      if (!hold) tx_if.tx_vld_i = 1'b0;
   endtask

   task automatic wait_eot(input string nm);
      int t = 0;
      @(negedge clk_i);
      while (tx_if.tx_eot_o !== 1'b1 && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 3000) begin
         n_checks++; n_fail++;
         $display("FAIL %s eot timeout", nm);
      end
      @(posedge clk_i); #1;
   endtask

   initial begin
      #5ms;
      n_fail++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      tx_if.tx_data_i = '0;
      tx_if.tx_vld_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      @(posedge clk_i); #1;
      chk("rdy after reset release", tx_if.tx_rdy_o, 1'b1);

      // mode 0, div 0, len 8
      dec_clear(0, 0);
      send(32'hA5, 8, 0, 0, 0, 0);
      wait_eot("mode0");
      chk_int("mode0 eot latency", eot_cyc - hs_cyc, 19);
      chk_int("mode0 word", dec_word[7:0], 8'hA5);
      chk_int("mode0 bits", dec_bits, 8);
      chk("mode0 rdy at T+20", tx_if.tx_rdy_o, 1'b1);

      // mode 3, div 3, len 32
      dec_clear(1, 1);
      send(32'hDEADBEEF, 32, 3, 1, 1, 0);
      wait_eot("mode3");
      chk_int("mode3 eot latency", eot_cyc - hs_cyc, 265);
      chk_int("mode3 word", dec_word, 32'hDEADBEEF);
      chk_int("mode3 edges", dec_edges, 64);

      // len 0 and len 40 both mean full width
      for (int k = 0; k < 2; k++) begin
         w = $urandom;
         dec_clear(0, 1);
         send(w, (k == 0) ? 6'd0 : 6'd40, 0, 0, 1, 0);
         wait_eot("fullwidth");
         chk_int("fullwidth word", dec_word, w);
         chk_int("fullwidth bits", dec_bits, 32);
         chk_int("fullwidth edges", dec_edges, 64);
      end

      // back-to-back words with valid held high
      dec_clear(0, 0);
      send(32'h12, 8, 1, 0, 0, 1);
      send(32'h34, 8, 1, 0, 0, 0);
      chk_int("b2b handshake at eot+1", hs_cyc, eot_cyc + 1);
      chk_int("b2b cs_n gap", last_gap, 2);
      wait_eot("b2b");
      chk_int("b2b words", dec_word[15:0], 16'h1234);

      // inputs changing mid-transfer are ignored; new cpol appears on idle sclk afterwards
      dec_clear(0, 0);
      send(32'h0000C3A1, 16, 2, 0, 0, 0);
      repeat (10) @(posedge clk_i);
      #1 cpol_i = 1'b1; clk_div_i = 8'd7; tx_if.tx_data_i = $urandom;
      wait_eot("midchange");
      chk_int("midchange eot latency", eot_cyc - hs_cyc, 103);
      chk_int("midchange word", dec_word[15:0], 16'hC3A1);
      chk("midchange sclk first idle", sclk_o, 1'b0);
      @(posedge clk_i); #1;
      chk("midchange sclk new cpol", sclk_o, 1'b1);

      // reset in the middle of SHIFT
      send(32'hFF, 8, 1, 1, 0, 0);
      repeat (6) @(posedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      chk("abort cs_n", cs_n_o, 1'b1);
      chk("abort sdo", sdo_o, 1'b0);
      chk("abort sclk", sclk_o, 1'b0);
      chk("abort eot", tx_if.tx_eot_o, 1'b0);
      chk("abort busy", tx_if.busy_o, 1'b0);
      repeat (3) @(posedge clk_i);
      #1 rstn_i = 1'b1; cpol_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rdy after abort", tx_if.tx_rdy_o, 1'b1);
      dec_clear(0, 0);
      send(32'h0F, 8, 0, 0, 0, 0);
      wait_eot("post-abort");
      chk_int("post-abort word", dec_word[7:0], 8'h0F);

      // random traffic, including valid while busy and arbitrary config changes
      for (int i = 0; i < 4000; i++) begin
         tx_if.tx_vld_i  = ($urandom_range(0, 3) == 0);
         tx_if.tx_data_i = $urandom;
         len_i           = LEN_W'($urandom_range(0, 63));
         clk_div_i       = DIV_W'($urandom_range(0, 3));
         cpol_i          = 1'($urandom_range(0, 1));
         cpha_i          = 1'($urandom_range(0, 1));
         @(posedge clk_i); #1;
      end
      tx_if.tx_vld_i = 1'b0;
      repeat (300) @(posedge clk_i);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
